// File: rtl/crypto_pkg.sv
// Shared cryptosystem definitions: byte S-box tables, mode encoding and the
// substitution engine's FSM state type.
package crypto_pkg;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } eng_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lane.sv
// Single-byte substitution: forward or inverse table lookup chosen by mode.
module sbox_lane
    import crypto_pkg::*;
(
    input  logic [7:0] din,
    input  logic       mode,
    output logic [7:0] dout
);

    // Table lookup in the requested direction
    always_comb begin
        dout = (mode == MODE_INV) ? INV_SBOX[din] : SBOX[din];
    end

endmodule

// File: rtl/substitution_engine.sv
// Multi-lane byte substitution engine. A word is latched on accept, then
// SUBS_PER_CYCLE lanes are substituted in place per beat, lane 0 first; the
// finished word is held on out_data until the downstream handshake.
module substitution_engine
    import crypto_pkg::*;
#(
    parameter int LANES          = 4,
    parameter int SUBS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_mode,
    output logic                 busy
);

    localparam int BEATS = LANES / SUBS_PER_CYCLE;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (LANES < 1 || SUBS_PER_CYCLE < 1 || (LANES % SUBS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("substitution_engine: SUBS_PER_CYCLE must be >= 1 and divide LANES (>= 1)");
    end

    eng_state_t          state, next_state;
    logic [8*LANES-1:0]  work, next_work;
    logic                mode_q;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                last_beat;
    int unsigned         beat_base;
    logic [7:0]          lane_in  [SUBS_PER_CYCLE];
    logic [7:0]          lane_out [SUBS_PER_CYCLE];

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == LAST_BEAT);
    assign beat_base = 32'(cnt) * 32'(SUBS_PER_CYCLE);

    for (genvar g = 0; g < SUBS_PER_CYCLE; g++) begin : g_lane
        sbox_lane u_lane (
            .din  (lane_in[g]),
            .mode (mode_q),
            .dout (lane_out[g])
        );
    end

    // Select the current beat's lanes from the work register
    always_comb begin
        for (int unsigned i = 0; i < SUBS_PER_CYCLE; i++) begin
            lane_in[i] = work[(beat_base + i) * 8 +: 8];
        end
    end

    // Merge the substituted lanes back into their original positions
    always_comb begin
        next_work = work;
        for (int unsigned i = 0; i < SUBS_PER_CYCLE; i++) begin
            next_work[(beat_base + i) * 8 +: 8] = lane_out[i];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DONE may hand straight over to a new word
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (accept) next_state = ST_BUSY;
            ST_BUSY: if (last_beat) next_state = ST_DONE;
            ST_DONE: if (out_ready) next_state = in_valid ? ST_BUSY : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_BUSY: busy = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Datapath: latch on accept, substitute in place per beat, publish on the last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work     <= '0;
            mode_q   <= MODE_FWD;
            cnt      <= '0;
            out_data <= '0;
            out_mode <= MODE_FWD;
        end else if (accept) begin
            work   <= in_data;
            mode_q <= in_mode;
            cnt    <= '0;
        end else if (state == ST_BUSY) begin
            work <= next_work;
            if (last_beat) begin
                out_data <= next_work;
                out_mode <= mode_q;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_substitution_engine.sv
// Bench for substitution_engine: directed table vectors and corner-case
// sequences on a default instance, plus randomized traffic on four
// configurations checked against a GF(2^8)-derived S-box model.
module tb_substitution_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    bit rand_go = 1'b0;
    logic rst_d, rst_r;

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box = multiplicative inverse in GF(2^8) followed by the affine map
    task automatic build_model();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = '0;
            for (int b = 1; b < 256; b++)
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            m_fwd[a] = s;
            m_inv[s] = 8'(a);
        end
    endtask

    function automatic logic [31:0] ref_word(logic [31:0] d, logic mode, int lanes);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < lanes; k++)
            r[8*k +: 8] = mode ? m_inv[d[8*k +: 8]] : m_fwd[d[8*k +: 8]];
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed instance (default parameters) ----------------
    logic        d_in_valid, d_in_ready, d_in_mode, d_out_valid, d_out_ready, d_out_mode, d_busy;
    logic [31:0] d_in_data, d_out_data;

    substitution_engine u_dut (
        .clk       (clk),
        .rst       (rst_d),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_data   (d_in_data),
        .in_mode   (d_in_mode),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_data  (d_out_data),
        .out_mode  (d_out_mode),
        .busy      (d_busy)
    );

    // Present a word, scramble the inputs after accept, count edges until out_valid
    task automatic submit(input logic [31:0] data, input logic mode, output int lat);
        @(negedge clk);
        d_in_valid  = 1'b1;
        d_in_data   = data;
        d_in_mode   = mode;
        d_out_ready = 1'b0;
        #1 check("accept_ready", 64'(d_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        d_in_valid = 1'b0;
        d_in_data  = $urandom;
        d_in_mode  = ~mode;
        lat = 0;
        while (!d_out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        d_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] data;
        logic        mode;
        logic [31:0] exp;
    } vec_t;

    // ---------------- randomized instances over four configurations ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int L = (gi == 3) ? 1 : 4;
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 1;
        localparam int B = L / S;

        logic           in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, busy;
        logic [8*L-1:0] in_data, out_data;
        bit             fin;

        substitution_engine #(.LANES(L), .SUBS_PER_CYCLE(S)) u_dut (
            .clk       (clk),
            .rst       (rst_r),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_mode   (in_mode),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_mode  (out_mode),
            .busy      (busy)
        );

        initial begin : rand_proc
            logic [31:0] q_data [$];
            logic        q_mode [$];
            bit          q_first [$];
            logic [31:0] d;
            int          acc_edge, done_words;
            bit          waiting, first_sent, stopping;
            in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mode = 1'b0;
            fin = 1'b0; waiting = 1'b0; first_sent = 1'b0; acc_edge = 0; done_words = 0;
            wait (rand_go);
            for (int c = 0; c < 700; c++) begin
                @(negedge clk);
                if (waiting && out_valid) begin
                    check($sformatf("cfg%0d_latency", gi), 64'(cyc - acc_edge), 64'(B));
                    waiting = 1'b0;
                end else if (waiting && (cyc - acc_edge) > B) begin
                    check($sformatf("cfg%0d_timeout", gi), 64'(cyc - acc_edge), 64'(B));
                    waiting = 1'b0;
                    q_data.delete(); q_mode.delete(); q_first.delete();
                end
                check($sformatf("cfg%0d_busy", gi), 64'(busy), 64'(waiting));
                check($sformatf("cfg%0d_valid", gi), 64'(out_valid), 64'(q_data.size() > 0 && !waiting));
                if (out_valid && q_data.size() > 0) begin
                    check($sformatf("cfg%0d_data", gi), 64'(out_data), 64'(q_data[0]));
                    check($sformatf("cfg%0d_mode", gi), 64'(out_mode), 64'(q_mode[0]));
                end
                stopping  = (c >= 600);
                out_ready = stopping ? 1'b1 : ($urandom_range(0, 3) != 0);
                in_valid  = stopping ? 1'b0 : ($urandom_range(0, 2) != 0);
                d         = first_sent ? $urandom : {4{8'h62}};
                in_data   = d[8*L-1:0];
                in_mode   = first_sent ? 1'($urandom) : 1'b1;
                #1;
                check($sformatf("cfg%0d_in_ready", gi), 64'(in_ready),
                      64'(q_data.size() == 0 || (!waiting && out_ready)));
                if (out_valid && out_ready && q_data.size() > 0) begin
                    if (q_first[0])
                        check($sformatf("cfg%0d_lane0_inv62", gi), 64'(out_data[7:0]), 64'hAB);
                    void'(q_data.pop_front()); void'(q_mode.pop_front()); void'(q_first.pop_front());
                    done_words++;
                end
                if (in_valid && in_ready) begin
                    q_data.push_back(ref_word(d, in_mode, L));
                    q_mode.push_back(in_mode);
                    q_first.push_back(!first_sent);
                    first_sent = 1'b1;
                    acc_edge   = cyc + 1;
                    waiting    = 1'b1;
                end
            end
            check($sformatf("cfg%0d_drained", gi), 64'(q_data.size()), 64'd0);
            check($sformatf("cfg%0d_enough_words", gi), 64'(done_words >= 20), 64'd1);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            fin = 1'b1;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        vec_t        tbl [$];
        int          lat;
        logic [31:0] exp_a;
        logic [31:0] w;
        rst_d = 1'b1; rst_r = 1'b1;
        d_in_valid = 1'b0; d_in_data = '0; d_in_mode = 1'b0; d_out_ready = 1'b0;
        build_model();

        tbl.push_back('{32'h7D521762, 1'b1, 32'h134887AB});
        tbl.push_back('{32'h134887AB, 1'b0, 32'h7D521762});
        tbl.push_back('{32'h00000000, 1'b0, 32'h63636363});
        tbl.push_back('{32'h00010203, 1'b0, 32'h637C777B});
        tbl.push_back('{32'h637C777B, 1'b1, 32'h00010203});
        tbl.push_back('{32'hFFFEFDFC, 1'b0, 32'h16BB54B0});
        for (int i = 0; i < 64; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            tbl.push_back('{w, 1'b0, ref_word(w, 1'b0, 4)});
            tbl.push_back('{w, 1'b1, ref_word(w, 1'b1, 4)});
        end

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(d_out_valid), 64'd0);
        check("rst_busy", 64'(d_busy), 64'd0);
        check("rst_out_data", 64'(d_out_data), 64'd0);
        check("rst_out_mode", 64'(d_out_mode), 64'd0);
        rst_d = 1'b0; rst_r = 1'b0;
        #1 check("rst_in_ready", 64'(d_in_ready), 64'd1);

        // table vectors
        foreach (tbl[i]) begin
            submit(tbl[i].data, tbl[i].mode, lat);
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("tbl%0d_data", i), 64'(d_out_data), 64'(tbl[i].exp));
            check($sformatf("tbl%0d_mode", i), 64'(d_out_mode), 64'(tbl[i].mode));
            drain();
        end

        // back-pressure: result held, new inputs ignored, then same-cycle handover
        exp_a = ref_word(32'h11223344, 1'b0, 4);
        submit(32'h11223344, 1'b0, lat);
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 10; i++) begin
            d_in_valid = 1'b1;
            d_in_data  = $urandom;
            d_in_mode  = 1'($urandom);
            #1;
            check("bp_in_ready", 64'(d_in_ready), 64'd0);
            check("bp_out_valid", 64'(d_out_valid), 64'd1);
            check("bp_out_data", 64'(d_out_data), 64'(exp_a));
            check("bp_out_mode", 64'(d_out_mode), 64'd0);
            @(negedge clk);
        end
        d_in_valid  = 1'b1;
        d_in_data   = 32'hCAFEF00D;
        d_in_mode   = 1'b1;
        d_out_ready = 1'b1;
        #1 check("handover_in_ready", 64'(d_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
        check("handover_valid_drop", 64'(d_out_valid), 64'd0);
        check("handover_busy", 64'(d_busy), 64'd1);
        lat = 0;
        while (!d_out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("handover_latency", 64'(lat), 64'd4);
        check("handover_data", 64'(d_out_data), 64'(ref_word(32'hCAFEF00D, 1'b1, 4)));
        check("handover_mode", 64'(d_out_mode), 64'd1);
        drain();

        // reset during beat 2 of a word
        @(negedge clk);
        d_in_valid = 1'b1;
        d_in_data  = 32'hA5A55A5A;
        d_in_mode  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_d = 1'b1;
        #1;
        check("midrst_busy", 64'(d_busy), 64'd0);
        check("midrst_out_valid", 64'(d_out_valid), 64'd0);
        check("midrst_in_ready", 64'(d_in_ready), 64'd1);
        @(negedge clk);
        rst_d = 1'b0;
        d_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_output", 64'(d_out_valid), 64'd0);
        end
        d_out_ready = 1'b0;
        submit(32'h00000000, 1'b0, lat);
        check("postrst_latency", 64'(lat), 64'd4);
        check("postrst_data", 64'(d_out_data), 64'h63636363);
        drain();

        // randomized traffic on all configurations
        rand_go = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) break;
            @(negedge clk);
        end
        check("rand_finished", 64'({g_cfg[3].fin, g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin}), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/substitution_engine.md
Name: substitution_engine

Overview:
Parametrised, multi-byte successor to the team's 8-bit inverse substitution block. It accepts a word of LANES bytes, runs each byte through either the forward or the inverse 8-bit S-box (per-transaction mode), and returns the word. Work is serialised over one or more beats, SUBS_PER_CYCLE lanes per beat, trading area for latency. It sits between the key-mixing stage and the permutation stage of the cryptosystem datapath, with valid/ready handshakes on both sides.

Parameters:
LANES, 4, number of 8-bit lanes per word; must be at least 1.
SUBS_PER_CYCLE, 1, S-box instances (lanes processed per beat); must divide LANES.
BEATS (localparam), LANES/SUBS_PER_CYCLE, beats per word.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input word present.
in_ready  out  1  engine can accept a word this cycle.
in_data  in  8*LANES  input word; lane k = bits [8k+7:8k].
in_mode  in  1  0 = forward substitution, 1 = inverse substitution.
out_valid  out  1  result word held on out_data.
out_ready  in  1  downstream accepts the result.
out_data  out  8*LANES  substituted word, same lane order as in_data.
out_mode  out  1  mode the result was produced with.
busy  out  1  high in BUSY state.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; work register, out_data, out_mode and beat counter cleared to 0; out_valid=0; busy=0; in_ready=1 once rst deasserts.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, latch in_mode, clear the beat counter, and go to BUSY.
- BUSY: in_ready=0; busy=1. Each cycle, substitute lanes [cnt*S, cnt*S+S-1] (S=SUBS_PER_CYCLE) of the latched word using the latched mode, and write them in place. cnt increments each cycle. When cnt==BEATS-1, the beat completes and the next state is DONE.
- DONE: out_valid=1; out_data and out_mode are stable until the handshake completes. in_ready=out_ready, which allows back-to-back operation.
  - out_ready=1 with no new input: go to IDLE.
  - out_ready=1 with in_valid=1: accept the new word in the same cycle and go directly to BUSY.
  - out_ready=0: hold DONE with all outputs unchanged and in_ready=0.
- Latency: word accepted at clock edge T; out_valid rises after edge T+BEATS. Default config: 4 cycles. SUBS_PER_CYCLE=LANES: 1 cycle.
- Throughput: one word per BEATS+1 cycles in steady state with out_ready held high.
- Lane order: lane 0 (LSB byte) is processed on beat 0.
- Mode is sampled only at accept. Changes on in_mode at other times are ignored.
- in_data is sampled only at accept. The source may change it afterwards.
- No combinational path from in_* to out_*. Only in_ready depends combinationally on out_ready, and only in DONE.
- Reset mid-operation (BUSY or DONE): the word is discarded, no output is produced, and the engine returns to IDLE.
- Forward and inverse tables are exact inverses: INV_SBOX[SBOX[x]]==x for all 256 x.

Decomposition:
- Shared package crypto_pkg:
  - 256x8 SBOX constant table.
  - 256x8 INV_SBOX constant table (the same table the existing 8-bit inverse block uses).
  - Mode constants MODE_FWD=1'b0 and MODE_INV=1'b1.
  - FSM state encoding for this engine.
- Sub-module sbox_lane: combinational, 8-bit in, mode, 8-bit out; selects SBOX or INV_SBOX. Instantiate SUBS_PER_CYCLE copies, fed by a beat-indexed lane mux.

Test Plan:
- Reset then idle (defaults): rst pulse -> out_valid=0, busy=0, out_data=0, and in_ready=1 from the first cycle after deassert.
- Inverse known values (defaults): in_data=32'h7D521762, in_mode=1 -> after 4 cycles out_valid=1, out_data = {INV_SBOX[8'h7D], INV_SBOX[8'h52], INV_SBOX[8'h17], INV_SBOX[8'h62]}, out_mode=1.
- Round trip: feed that result back with in_mode=0 -> out_data=32'h7D521762. Also sweep all 256 byte values across lanes in both directions, checking against the package tables.
- Back-pressure: out_ready=0 for 10 cycles in DONE -> out_data/out_valid stable, in_ready=0, and in_data changes are ignored. Then out_ready=1 with a new in_valid -> accepted in the same cycle, and the next result arrives BEATS cycles later.
- Reset mid-BUSY: assert rst during beat 2 of a word -> immediate IDLE, out_valid never asserted for that word. The next word (32'h00000000, mode 0) yields {4{SBOX[8'h00]}}.
- Parameter sweep:
  - LANES=4, SUBS_PER_CYCLE=2: latency 2.
  - LANES=4, SUBS_PER_CYCLE=4: latency 1.
  - LANES=1, SUBS_PER_CYCLE=1: latency 1; in_data=8'h62, mode 1 -> INV_SBOX[8'h62].
  - Every config: random back-to-back traffic with random out_ready matches the reference model.
